// File: rtl/s_axis_cc_arb_pkg.sv
// s_axis_cc_arbiter shared types and sideband bit positions.
// Watchdog build macro: S_AXIS_CC_ARB_TIMEOUT_EN.
package s_axis_cc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  localparam int TUSER_DISCONTINUE_BIT = 3;
  localparam int TUSER_ECRC_BIT        = 0;

endpackage

// File: rtl/s_axis_cc_arbiter_if.sv
// Source-side and CC-side stream bundle of the CC arbiter.
// slave: arbiter view; master: environment view.
interface s_axis_cc_arbiter_if #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [NUM_SRC*DATA_WIDTH-1:0] s_src_tdata;
  logic [NUM_SRC*KEEP_WIDTH-1:0] s_src_tkeep;
  logic [NUM_SRC-1:0]            s_src_tlast;
  logic [NUM_SRC*4-1:0]          s_src_tuser;
  logic [NUM_SRC-1:0]            s_src_tvalid;
  logic [NUM_SRC-1:0]            s_src_tready;

  logic [DATA_WIDTH-1:0]         m_axis_cc_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_cc_tkeep;
  logic                          m_axis_cc_tlast;
  logic [3:0]                    m_axis_cc_tuser;
  logic                          m_axis_cc_tvalid;
  logic                          m_axis_cc_tready;

  modport slave (
    input  s_src_tdata, s_src_tkeep, s_src_tlast,
    input  s_src_tuser, s_src_tvalid,
    output s_src_tready,
    output m_axis_cc_tdata, m_axis_cc_tkeep,
    output m_axis_cc_tlast, m_axis_cc_tuser,
    output m_axis_cc_tvalid,
    input  m_axis_cc_tready
  );

  modport master (
    output s_src_tdata, s_src_tkeep, s_src_tlast,
    output s_src_tuser, s_src_tvalid,
    input  s_src_tready,
    input  m_axis_cc_tdata, m_axis_cc_tkeep,
    input  m_axis_cc_tlast, m_axis_cc_tuser,
    input  m_axis_cc_tvalid,
    output m_axis_cc_tready
  );
endinterface

// File: rtl/s_axis_cc_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester above last_i,
// wrapping; output is one-hot (zero when nothing requests).
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  pick_o
);
  int idx;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick_o = '0;
    idx    = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N;
      if (req_i[idx]) begin
        pick_o      = '0;
        pick_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/s_axis_cc_arbiter.sv
// Packet-granular round-robin arbiter onto the PCIe CC stream.
// Watchdog abort enabled by S_AXIS_CC_ARB_TIMEOUT_EN.
module s_axis_cc_arbiter
  import s_axis_cc_arb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input  logic               user_clk,
  input  logic               user_reset,
  s_axis_cc_arbiter_if.slave bus,
  output logic [NUM_SRC-1:0] grant,
  output logic               timeout_err
);
  localparam int IW = $clog2(NUM_SRC);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d, pick;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d, pidx;
  logic               sv, sl;

`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
  logic [15:0]        cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               tmo_q, tmo_d;
`endif

  assign sv = bus.s_src_tvalid[gidx_q];
  assign sl = bus.s_src_tlast[gidx_q];

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
    .req_i  (bus.s_src_tvalid),
    .last_i (last_q),
    .pick_o (pick)
  );

  // One-hot pick to index for the output mux.
  always_comb begin
    pidx = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (pick[i]) pidx = IW'(i);
  end

  // Next state, passthrough mux and watchdog counting.
  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    gidx_d               = gidx_q;
    last_d               = last_q;
    bus.m_axis_cc_tdata  = '0;
    bus.m_axis_cc_tkeep  = '0;
    bus.m_axis_cc_tlast  = 1'b0;
    bus.m_axis_cc_tuser  = '0;
    bus.m_axis_cc_tvalid = 1'b0;
    bus.s_src_tready     = '0;
`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
    cnt_d                = cnt_q;
    armed_d              = armed_q;
    tmo_d                = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.s_src_tvalid) begin
          grant_d = pick;
          gidx_d  = pidx;
          state_d = PASS;
`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
          cnt_d   = '0;
          armed_d = 1'b0;
`endif
        end
      end
      PASS: begin
        bus.m_axis_cc_tdata  =
          bus.s_src_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
        bus.m_axis_cc_tkeep  =
          bus.s_src_tkeep[gidx_q*KEEP_WIDTH +: KEEP_WIDTH];
        bus.m_axis_cc_tuser  = bus.s_src_tuser[gidx_q*4 +: 4];
        bus.m_axis_cc_tlast  = sl;
        bus.m_axis_cc_tvalid = sv;
        bus.s_src_tready[gidx_q] = bus.m_axis_cc_tready;
        if (sv && bus.m_axis_cc_tready) begin
`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
          cnt_d   = '0;
          armed_d = 1'b1;
`endif
          if (sl) begin
            last_d  = gidx_q;
            grant_d = '0;
            state_d = IDLE;
          end
        end
`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
        else if (armed_q && !sv) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT)) begin
            state_d = ABORT;
            tmo_d   = 1'b1;
          end
        end
`endif
      end
`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
      ABORT: begin
        bus.m_axis_cc_tvalid = 1'b1;
        bus.m_axis_cc_tlast  = 1'b1;
        bus.m_axis_cc_tkeep  = '1;
        bus.m_axis_cc_tuser[TUSER_DISCONTINUE_BIT] = 1'b1;
        if (bus.m_axis_cc_tready) state_d = DRAIN;
      end
      DRAIN: begin
        bus.s_src_tready[gidx_q] = 1'b1;
        if (sv && sl) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_SRC - 1);
`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      armed_q <= 1'b0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign grant = grant_q;
`ifdef S_AXIS_CC_ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: doc/s_axis_cc_arbiter.md
# s_axis_cc_arbiter

Packet-granular round-robin arbiter that shares the 128-bit PCIe Completer Completion (CC) stream between NUM_SRC completion sources. Examples of sources are the MMIO completer and the config-space responder. It sits directly upstream of the CC adapter, on user_clk. Each source's packet passes through whole; packets from different sources never interleave. An optional watchdog aborts a packet whose source stalls mid-packet.

## Interface
Parameters:
- NUM_SRC, 2: number of requesting sources (2..8).
- DATA_WIDTH, 128: beat width in bits.
- KEEP_WIDTH, DATA_WIDTH/8: byte-enable width.
- TIMEOUT, 255: mid-packet idle cycles before abort (watchdog build only; 1..65535).

Ports:
- user_clk, in, 1: single clock. All logic is on its rising edge.
- user_reset, in, 1: synchronous, active-high reset.
- s_src_tdata, in, NUM_SRC*DATA_WIDTH: per-source data. Source i occupies slice i.
- s_src_tkeep, in, NUM_SRC*KEEP_WIDTH: per-source byte enables.
- s_src_tlast, in, NUM_SRC: per-source end of packet.
- s_src_tuser, in, NUM_SRC*4: per-source sideband. Bit 3 is discontinue; bit 0 is ECRC.
- s_src_tvalid, in, NUM_SRC: per-source valid.
- s_src_tready, out, NUM_SRC: per-source ready. At most one bit is high at a time.
- m_axis_cc_tdata, out, DATA_WIDTH: to the CC adapter.
- m_axis_cc_tkeep, out, KEEP_WIDTH.
- m_axis_cc_tlast, out, 1.
- m_axis_cc_tuser, out, 4.
- m_axis_cc_tvalid, out, 1.
- m_axis_cc_tready, in, 1.
- grant, out, NUM_SRC: one-hot owner of the current packet. All zero when idle.
- timeout_err, out, 1: one-cycle pulse when an abort is issued.

## Operation
- States: IDLE, PASS. ABORT and DRAIN exist only with the watchdog.
- IDLE:
  - Outputs are quiet: m_axis_cc_tvalid=0 and s_src_tready=0.
  - If any s_src_tvalid is high, pick the first requester searching upward (with wrap) from last_grant+1.
  - Register the pick in grant and go to PASS.
- PASS: pure combinational passthrough of the granted source.
  - m_axis_cc_* = source g's signals.
  - s_src_tready[g] = m_axis_cc_tready.
  - All other ready bits are 0.
- On an accepted beat (valid & ready) with tlast=1:
  - last_grant <= g.
  - grant <= 0.
  - Go to IDLE.
- A non-granted source's tvalid is never dropped by the arbiter. It waits, in accordance with AXI-Stream.
- Fairness: a requester waits for at most NUM_SRC-1 other packets before it is granted.

## Timing
- Reset values:
  - State IDLE.
  - grant=0.
  - last_grant=NUM_SRC-1, so source 0 wins first.
  - m_axis_cc_tvalid=0, s_src_tready=0, timeout_err=0.
  - Watchdog counter 0.
- Arbitration costs exactly one IDLE cycle per packet. The first beat appears on m_axis_cc the cycle after the grant registers.
- PASS adds zero latency: the ready/valid path is combinational through a NUM_SRC:1 mux. There is no buffering.
- Simultaneous requests: the round-robin order decides. A request arriving in the same cycle a packet ends is seen in the following IDLE cycle.
- Single-beat packets (tlast on the first beat) are legal. Each one takes 2 cycles: IDLE, then PASS.
- Reset mid-packet: return to IDLE immediately. The downstream adapter is reset by the same user_reset, so truncation there is acceptable.

## Configuration
- Macro: S_AXIS_CC_ARB_TIMEOUT_EN.
- With S_AXIS_CC_ARB_TIMEOUT_EN:
  - A 16-bit counter runs in PASS only after at least one beat of the packet has been accepted.
  - It increments on each cycle where s_src_tvalid[g]=0.
  - It clears on any accepted beat and on entry to PASS.
  - When the count reaches TIMEOUT, go to ABORT and pulse timeout_err.
  - ABORT: drive m_axis_cc_tvalid=1, tlast=1, tuser=4'b1000 (discontinue), tkeep all ones, tdata=0. s_src_tready=0. Hold these until m_axis_cc_tready.
  - Then go to DRAIN. DRAIN sets s_src_tready[g]=1 and discards beats until source g's tlast is accepted, then goes to IDLE.
  - A stall before the first beat never times out.
- Without the macro: no counter, no ABORT or DRAIN states, timeout_err tied to 0. A stalled source holds the stream indefinitely.

## Structure
- Package s_axis_cc_arb_pkg holds:
  - the state enum (IDLE, PASS, ABORT, DRAIN);
  - TUSER_DISCONTINUE_BIT=3;
  - TUSER_ECRC_BIT=0.
- Sub-module rr_pick handles the round-robin selection:
  - Inputs: a request vector and last_grant.
  - Output: a one-hot pick. It is purely combinational and reusable for the RQ path.
- The top level holds the FSM, the output mux, and the watchdog.

## Test plan
- Single source: source 0 sends a 3-beat packet with m_axis_cc_tready=1.
  - grant=01 after one IDLE cycle.
  - 3 beats appear unchanged, the 3rd with tlast.
  - grant returns to 00.
- Contention: both sources request continuously, each sending 1-beat packets.
  - Output order is 0,1,0,1.
  - One IDLE cycle separates each packet.
  - s_src_tready is never high for both sources at once.
- Backpressure: m_axis_cc_tready toggles every cycle during a 4-beat packet from source 1.
  - Every beat is transferred exactly once.
  - tdata matches the input in order.
- Late request: source 1 asserts tvalid during source 0's last beat.
  - Source 1 is granted in the next IDLE cycle.
  - Source 0's packet is not interrupted.
- Watchdog build, TIMEOUT=4: source 0 sends 1 beat, then drops tvalid.
  - After 4 idle cycles, timeout_err pulses.
  - One beat is emitted with tlast=1 and tuser=4'b1000.
  - Source 0's remaining beats are drained with no output; source 1 is granted afterwards.
- Reset mid-packet: assert user_reset during beat 2 of 4.
  - The next cycle shows grant=0, m_axis_cc_tvalid=0, and s_src_tready=0.
  - Source 0 wins first after reset.
